game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level play controller for the brick game; it sequences the render/physics datapath.
- Takes debounced-level buttons, a per-frame tick and physics events.
- Produces the 3-bit game `state` and 3-bit aim `angle` consumed by the renderer, plus the launch pulse, the brick-init handshake, lives and level.
- Sits between the input pins and the physics, brick-memory and render blocks.

Parameters:
- INIT_LIVES, 3, lives loaded on a new game (1..3).
- REPEAT_FRAMES, 8, frames between angle auto-repeat steps while left/right is held.
- END_FRAMES, 60, minimum frames spent in WIN/LOSE before start is accepted.
- MAX_LEVEL, 3, highest level index; level wraps to 0 after it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_start  in  1  raw start button, asynchronous to clk
- btn_left  in  1  raw aim-left button
- btn_right  in  1  raw aim-right button
- btn_fire  in  1  raw launch button
- frame_tick  in  1  one-cycle pulse per video frame
- ball_lost  in  1  one-cycle pulse from physics, ball passed paddle
- bricks_left  in  7  live brick count from brick memory (0..64)
- init_ack  in  1  brick memory finished loading the level pattern
- state  out  3  0 IDLE, 1 SETUP, 2 AIM, 3 PLAY, 4 WIN, 5 LOSE
- angle  out  3  aim index 0..5 (0 = far left, 5 = far right)
- launch  out  1  one-cycle pulse, ball released
- init_req  out  1  level-load request, held until init_ack
- level  out  2  current level index for pattern select
- lives  out  2  remaining lives

Behaviour:
Reset (rst low, async):
- state=IDLE, angle=4, launch=0, init_req=0, level=0, lives=INIT_LIVES.
- Frame counters and synchronizer flops clear to 0.

Input conditioning:
- Each button passes a 2-flop synchronizer, then a rising-edge detector.
- Effective latency: 3 cycles from pin to edge pulse.

State machine (one transition per clock; all outputs registered):
- IDLE: on start edge → SETUP; lives=INIT_LIVES, level=0.
- SETUP:
  - init_req=1 from the cycle after entry.
  - Cycle init_ack seen: init_req drops, → AIM, angle=4.
  - init_ack is ignored in any other state.
- AIM:
  - Left edge: angle−1, saturating at 0. Right edge: angle+1, saturating at 5.
  - While one direction is held, angle also steps every REPEAT_FRAMES frame_ticks; the repeat counter restarts on each edge.
  - Left and right both active in the same cycle: no change.
  - Fire edge: launch=1 for exactly one cycle, → PLAY. Angle is frozen from that cycle.
- PLAY:
  - bricks_left==0: → WIN. This has priority over ball_lost in the same cycle.
  - Else ball_lost with lives>1: lives−1, → AIM, angle=4.
  - Else ball_lost with lives==1: lives=0, → LOSE.
- WIN / LOSE:
  - An end counter counts frame_ticks, saturating at END_FRAMES.
  - Start edge is accepted only when the counter == END_FRAMES.
  - WIN + start: level = level+1 (wraps to 0 after MAX_LEVEL), lives unchanged, → SETUP.
  - LOSE + start: level=0, lives=INIT_LIVES, → SETUP.
  - The end counter clears on entry to WIN/LOSE.
- Encodings 6 and 7 are illegal: next cycle → IDLE with reset values.

Other rules:
- Buttons have no effect outside the states listed above.
- launch never asserts outside the AIM→PLAY transition.
- bricks_left is sampled only in PLAY.
- Reset mid-operation (including SETUP with init_req high): everything returns to reset values immediately; init_req drops asynchronously.

Decomposition:
- Package game_pkg:
  - state encoding localparams (ST_IDLE..ST_LOSE, 3 bits).
  - ANGLE_MIN=0, ANGLE_MAX=5, ANGLE_DEFAULT=4.
  - Shared by the renderer, physics and this block.
- Sub-module btn_sync: 2-flop synchronizer plus rising-edge pulse plus held-level output; instantiated four times.
- Remaining logic (FSM, angle/repeat counter, end counter, lives/level registers) stays in game_sequencer.

Test Plan:
1. Reset, then start edge, then init_ack 5 cycles after init_req rises → state 0→1→2, init_req high exactly until ack, angle=4, lives=3, level=0.
2. In AIM: right edge ×3 gives angle 5 (saturates). Left held for 40 frame_ticks with REPEAT_FRAMES=8 gives angle 5→0 and stays at 0. Left and right pressed together give no change.
3. In AIM at angle=1, fire edge → launch high for 1 cycle, state=3, angle stays 1 despite later left/right presses.
4. In PLAY with lives=3, ball_lost → lives=2, state=2, angle=4. Repeat twice more → lives=0, state=5. Start before 60 frames is ignored; after 60 frames, start → state=1, lives=3, level=0.
5. In PLAY, bricks_left=0 and ball_lost in the same cycle → state=4, lives unchanged. After END_FRAMES, start → level=1, state=1. From level 3, a win + start → level=0.
6. Assert rst low while in SETUP with init_req=1 → init_req=0 and state=0 with no clock edge. Force state=6 → IDLE next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the brick game: state codes and aim angle limits.
// Used by the sequencer, renderer and physics blocks.
package game_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_AIM   = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;
    localparam logic [2:0] ST_LOSE  = 3'd5;

    localparam logic [2:0] ANGLE_MIN     = 3'd0;
    localparam logic [2:0] ANGLE_MAX     = 3'd5;
    localparam logic [2:0] ANGLE_DEFAULT = 3'd4;

    // One saturating aim step toward the left (i_left=1) or right.
    function automatic logic [2:0] angle_step(
        input logic [2:0] i_angle,
        input logic       i_left
    );
        logic [2:0] r;
        r = i_angle;
        if (i_left) begin
            if (i_angle != ANGLE_MIN) r = i_angle - 3'd1;
        end else begin
            if (i_angle != ANGLE_MAX) r = i_angle + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_sequencer_btn_sync.sv
// Button conditioner: two-flop synchronizer, registered rising-edge pulse
// and a held level aligned with that pulse.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise,
    output logic o_held
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_held = r_prev;

endmodule

// File: rtl/game_sequencer.sv
// Play controller for the brick game: buttons, frame ticks and physics
// events drive the game state, aim angle, launch, level load, lives, level.
module game_sequencer
    import game_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int REPEAT_FRAMES = 8,
    parameter int END_FRAMES    = 60,
    parameter int MAX_LEVEL     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       frame_tick,
    input  logic       ball_lost,
    input  logic [6:0] bricks_left,
    input  logic       init_ack,
    output logic [2:0] state,
    output logic [2:0] angle,
    output logic       launch,
    output logic       init_req,
    output logic [1:0] level,
    output logic [1:0] lives
);

    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam int EW = $clog2(END_FRAMES + 1);

    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_FRAMES - 1);
    localparam logic [EW-1:0] END_MAX    = EW'(END_FRAMES);
    localparam logic [1:0]    LIVES_INIT = 2'(INIT_LIVES);
    localparam logic [1:0]    LEVEL_TOP  = 2'(MAX_LEVEL);

    logic w_start_rise;
    logic w_left_rise;
    logic w_right_rise;
    logic w_fire_rise;
    logic w_left_held;
    logic w_right_held;
    logic w_unused_start_held;
    logic w_unused_fire_held;

    btn_sync u_start (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_start),
        .o_rise (w_start_rise),
        .o_held (w_unused_start_held)
    );

    btn_sync u_left (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_left),
        .o_rise (w_left_rise),
        .o_held (w_left_held)
    );

    btn_sync u_right (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_right),
        .o_rise (w_right_rise),
        .o_held (w_right_held)
    );

    btn_sync u_fire (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_fire),
        .o_rise (w_fire_rise),
        .o_held (w_unused_fire_held)
    );

    logic [2:0]    r_state;
    logic [2:0]    r_angle;
    logic          r_launch;
    logic          r_init_req;
    logic [1:0]    r_level;
    logic [1:0]    r_lives;
    logic [RW-1:0] r_rep_cnt;
    logic [EW-1:0] r_end_cnt;

    logic w_both_held;
    logic w_one_held;
    logic w_end_ready;

    assign w_both_held = w_left_held & w_right_held;
    assign w_one_held  = w_left_held ^ w_right_held;
    assign w_end_ready = (r_end_cnt == END_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_angle    <= ANGLE_DEFAULT;
            r_launch   <= 1'b0;
            r_init_req <= 1'b0;
            r_level    <= 2'd0;
            r_lives    <= LIVES_INIT;
            r_rep_cnt  <= '0;
            r_end_cnt  <= '0;
        end else begin
            r_launch <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_state <= ST_SETUP;
                        r_lives <= LIVES_INIT;
                        r_level <= 2'd0;
                    end
                end
                ST_SETUP: begin
                    if (init_ack) begin
                        r_init_req <= 1'b0;
                        r_state    <= ST_AIM;
                        r_angle    <= ANGLE_DEFAULT;
                        r_rep_cnt  <= '0;
                    end else begin
                        r_init_req <= 1'b1;
                    end
                end
                ST_AIM: begin
                    // Fire wins over any aim input in the same cycle.
                    if (w_fire_rise) begin
                        r_launch  <= 1'b1;
                        r_state   <= ST_PLAY;
                        r_rep_cnt <= '0;
                    end else if (w_both_held) begin
                        r_rep_cnt <= '0;
                    end else if (w_left_rise | w_right_rise) begin
                        r_angle   <= angle_step(r_angle, w_left_rise);
                        r_rep_cnt <= '0;
                    end else if (w_one_held) begin
                        if (frame_tick) begin
                            if (r_rep_cnt == REP_LAST) begin
                                r_angle   <= angle_step(r_angle, w_left_held);
                                r_rep_cnt <= '0;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_rep_cnt <= '0;
                    end
                end
                ST_PLAY: begin
                    if (bricks_left == 7'd0) begin
                        r_state   <= ST_WIN;
                        r_end_cnt <= '0;
                    end else if (ball_lost) begin
                        if (r_lives > 2'd1) begin
                            r_lives   <= r_lives - 2'd1;
                            r_state   <= ST_AIM;
                            r_angle   <= ANGLE_DEFAULT;
                            r_rep_cnt <= '0;
                        end else begin
                            r_lives   <= 2'd0;
                            r_state   <= ST_LOSE;
                            r_end_cnt <= '0;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (frame_tick && !w_end_ready) begin
                        r_end_cnt <= r_end_cnt + 1'b1;
                    end
                    if (w_start_rise && w_end_ready) begin
                        r_state <= ST_SETUP;
                        if (r_state == ST_WIN) begin
                            r_level <= (r_level == LEVEL_TOP) ?
                                       2'd0 : r_level + 2'd1;
                        end else begin
                            r_level <= 2'd0;
                            r_lives <= LIVES_INIT;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_angle    <= ANGLE_DEFAULT;
                    r_init_req <= 1'b0;
                    r_level    <= 2'd0;
                    r_lives    <= LIVES_INIT;
                    r_rep_cnt  <= '0;
                    r_end_cnt  <= '0;
                end
            endcase
        end
    end

    assign state    = r_state;
    assign angle    = r_angle;
    assign launch   = r_launch;
    assign init_req = r_init_req;
    assign level    = r_level;
    assign lives    = r_lives;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: walks the game through every state
// with hand-computed expectations for state, angle, lives and level.
module tb_game_sequencer;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       frame_tick;
    logic       ball_lost;
    logic [6:0] bricks_left;
    logic       init_ack;
    logic [2:0] state;
    logic [2:0] angle;
    logic       launch;
    logic       init_req;
    logic [1:0] level;
    logic [1:0] lives;

    int n_tests;
    int n_fail;

    game_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start   (btn_start),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_fire    (btn_fire),
        .frame_tick  (frame_tick),
        .ball_lost   (ball_lost),
        .bricks_left (bricks_left),
        .init_ack    (init_ack),
        .state       (state),
        .angle       (angle),
        .launch      (launch),
        .init_req    (init_req),
        .level       (level),
        .lives       (lives)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc(4);
        btn_start = 1'b0;
        cyc(4);
    endtask

    task automatic do_ack();
        init_ack = 1'b1;
        cyc(1);
        init_ack = 1'b0;
        n_tests++;
        if (state !== 3'd2 || init_req !== 1'b0 || angle !== 3'd4) begin
            n_fail++;
            $display("FAIL ack_to_aim state=%0d req=%0b angle=%0d exp 2/0/4",
                     state, init_req, angle);
        end
    endtask

    task automatic fire_to_play();
        btn_fire = 1'b1;
        cyc(4);
        n_tests++;
        if (launch !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL fire launch=%0b state=%0d exp 1/3", launch, state);
        end
        cyc(1);
        n_tests++;
        if (launch !== 1'b0) begin
            n_fail++;
            $display("FAIL launch_width launch=%0b exp 0", launch);
        end
        btn_fire = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(3);
        n_tests++;
        if (state !== 3'd0 || angle !== 3'd4 || launch !== 1'b0 ||
            init_req !== 1'b0 || level !== 2'd0 || lives !== 2'd3) begin
            n_fail++;
            $display("FAIL reset st=%0d ang=%0d l=%0b rq=%0b lv=%0d li=%0d exp 0/4/0/0/0/3",
                     state, angle, launch, init_req, level, lives);
        end
        rst = 1'b1;
        cyc(2);
    endtask

    task automatic test_start_setup();
        btn_start = 1'b1;
        cyc(4);
        n_tests++;
        if (state !== 3'd1 || init_req !== 1'b0) begin
            n_fail++;
            $display("FAIL setup_entry state=%0d req=%0b exp 1/0", state, init_req);
        end
        cyc(1);
        btn_start = 1'b0;
        n_tests++;
        if (init_req !== 1'b1) begin
            n_fail++;
            $display("FAIL init_req_rise req=%0b exp 1", init_req);
        end
        cyc(4);
        n_tests++;
        if (init_req !== 1'b1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL init_req_hold req=%0b state=%0d exp 1/1", init_req, state);
        end
        do_ack();
        n_tests++;
        if (lives !== 2'd3 || level !== 2'd0) begin
            n_fail++;
            $display("FAIL new_game lives=%0d level=%0d exp 3/0", lives, level);
        end
    endtask

    task automatic test_aim();
        for (int i = 0; i < 3; i++) begin
            btn_right = 1'b1;
            cyc(4);
            btn_right = 1'b0;
            cyc(4);
        end
        n_tests++;
        if (angle !== 3'd5) begin
            n_fail++;
            $display("FAIL right_sat angle=%0d exp 5", angle);
        end
        btn_left = 1'b1;
        cyc(4);
        n_tests++;
        if (angle !== 3'd4) begin
            n_fail++;
            $display("FAIL left_edge angle=%0d exp 4", angle);
        end
        frames(7);
        n_tests++;
        if (angle !== 3'd4) begin
            n_fail++;
            $display("FAIL repeat_early angle=%0d exp 4", angle);
        end
        frames(1);
        n_tests++;
        if (angle !== 3'd3) begin
            n_fail++;
            $display("FAIL repeat_step angle=%0d exp 3", angle);
        end
        frames(32);
        n_tests++;
        if (angle !== 3'd0) begin
            n_fail++;
            $display("FAIL left_sat angle=%0d exp 0", angle);
        end
        btn_left = 1'b0;
        cyc(4);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        cyc(4);
        frames(10);
        n_tests++;
        if (angle !== 3'd0) begin
            n_fail++;
            $display("FAIL both_pressed angle=%0d exp 0", angle);
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        cyc(4);
        bricks_left = 7'd0;
        cyc(2);
        bricks_left = 7'd40;
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL bricks_in_aim state=%0d exp 2", state);
        end
    endtask

    task automatic test_fire();
        btn_right = 1'b1;
        cyc(4);
        btn_right = 1'b0;
        cyc(4);
        n_tests++;
        if (angle !== 3'd1) begin
            n_fail++;
            $display("FAIL aim_to_1 angle=%0d exp 1", angle);
        end
        fire_to_play();
        btn_right = 1'b1;
        cyc(4);
        frames(10);
        btn_right = 1'b0;
        btn_left  = 1'b1;
        cyc(6);
        btn_left = 1'b0;
        cyc(4);
        n_tests++;
        if (angle !== 3'd1 || state !== 3'd3 || launch !== 1'b0) begin
            n_fail++;
            $display("FAIL angle_frozen angle=%0d state=%0d launch=%0b exp 1/3/0",
                     angle, state, launch);
        end
    endtask

    task automatic test_lose();
        for (int i = 0; i < 2; i++) begin
            ball_lost = 1'b1;
            cyc(1);
            ball_lost = 1'b0;
            n_tests++;
            if (lives !== 2'(2 - i) || state !== 3'd2 || angle !== 3'd4) begin
                n_fail++;
                $display("FAIL ball_lost%0d lives=%0d state=%0d angle=%0d exp %0d/2/4",
                         i, lives, state, angle, 2 - i);
            end
            fire_to_play();
        end
        ball_lost = 1'b1;
        cyc(1);
        ball_lost = 1'b0;
        n_tests++;
        if (lives !== 2'd0 || state !== 3'd5) begin
            n_fail++;
            $display("FAIL last_life lives=%0d state=%0d exp 0/5", lives, state);
        end
        frames(59);
        press_start();
        n_tests++;
        if (state !== 3'd5) begin
            n_fail++;
            $display("FAIL early_start state=%0d exp 5", state);
        end
        frames(1);
        press_start();
        n_tests++;
        if (state !== 3'd1 || lives !== 2'd3 || level !== 2'd0) begin
            n_fail++;
            $display("FAIL lose_restart state=%0d lives=%0d level=%0d exp 1/3/0",
                     state, lives, level);
        end
        do_ack();
    endtask

    task automatic test_win();
        fire_to_play();
        bricks_left = 7'd0;
        ball_lost   = 1'b1;
        cyc(1);
        ball_lost   = 1'b0;
        bricks_left = 7'd40;
        n_tests++;
        if (state !== 3'd4 || lives !== 2'd3) begin
            n_fail++;
            $display("FAIL win_priority state=%0d lives=%0d exp 4/3", state, lives);
        end
        frames(60);
        press_start();
        n_tests++;
        if (state !== 3'd1 || level !== 2'd1 || lives !== 2'd3) begin
            n_fail++;
            $display("FAIL win_next state=%0d level=%0d lives=%0d exp 1/1/3",
                     state, level, lives);
        end
        for (int i = 2; i <= 4; i++) begin
            do_ack();
            fire_to_play();
            bricks_left = 7'd0;
            cyc(1);
            bricks_left = 7'd40;
            frames(60);
            press_start();
            n_tests++;
            if (state !== 3'd1 || level !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL level_step%0d state=%0d level=%0d exp 1/%0d",
                         i, state, level, i % 4);
            end
        end
    endtask

    task automatic test_async_reset();
        n_tests++;
        if (init_req !== 1'b1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_reset req=%0b state=%0d exp 1/1", init_req, state);
        end
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (init_req !== 1'b0 || state !== 3'd0 || level !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset req=%0b state=%0d level=%0d exp 0/0/0",
                     init_req, state, level);
        end
        cyc(1);
        rst = 1'b1;
        cyc(2);
    endtask

    task automatic test_illegal();
        press_start();
        do_ack();
        btn_right = 1'b1;
        cyc(4);
        btn_right = 1'b0;
        cyc(4);
        @(negedge clk);
        force dut.r_state = 3'd6;
        #1;
        release dut.r_state;
        @(posedge clk);
        #1;
        n_tests++;
        if (state !== 3'd0 || angle !== 3'd4 || lives !== 2'd3) begin
            n_fail++;
            $display("FAIL illegal_state state=%0d angle=%0d lives=%0d exp 0/4/3",
                     state, angle, lives);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        btn_start   = 1'b0;
        btn_left    = 1'b0;
        btn_right   = 1'b0;
        btn_fire    = 1'b0;
        frame_tick  = 1'b0;
        ball_lost   = 1'b0;
        bricks_left = 7'd40;
        init_ack    = 1'b0;
        test_reset();
        test_start_setup();
        test_aim();
        test_fire();
        test_lose();
        test_win();
        test_async_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
